// File: rtl/sbox_selftest_pkg.sv
// Shared definitions for the masked S-box self-test: FSM states, LFSR
// polynomial taps and the AES SubBytes table used by the golden reference.
package sbox_selftest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // x^64 + x^63 + x^61 + x^60 + 1, Fibonacci form shifting left:
    // feedback = s[63] ^ s[62] ^ s[60] ^ s[59].
    localparam int          LFSR_W    = 64;
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    localparam int            ERR_W   = 9;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    localparam logic [7:0] AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // One LFSR step: shift left, feedback enters at bit 0.
    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sbox_selftest_ref.sv
// Unmasked combinational AES SubBytes, the golden value on the check path.
module aes_sbox_ref
    import sbox_selftest_pkg::*;
(
    input  logic [7:0] x_i,
    output logic [7:0] y_o
);

    assign y_o = AES_SBOX[x_i];

endmodule

// File: rtl/sbox_selftest.sv
// Self-test harness for a masked AES S-box. It walks x = 0..NUM_VEC-1,
// splits each x into SHARES Boolean shares using LFSR masks, supplies fresh
// randomness, and compares the recombined DUT output LAT cycles later with
// the unmasked reference. Handshake: start is a level sampled only in IDLE;
// done is a one-cycle pulse in DONE; results hold until the next start.
module sbox_selftest
    import sbox_selftest_pkg::*;
#(
    parameter int SHARES  = 2,
    parameter int RAND_W  = 19,
    parameter int LAT     = 4,
    parameter int NUM_VEC = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           seed,
    output logic [8*SHARES-1:0]   sbox_in,
    output logic [RAND_W-1:0]     sbox_rand,
    input  logic [8*SHARES-1:0]   sbox_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [7:0]            first_fail_x,
    output state_e                dbg_state_o
);

    localparam int MASK_W = 8 * (SHARES - 1);

    if (RAND_W + MASK_W > LFSR_W) begin : g_bad_rand_w
        $error("sbox_selftest: RAND_W + 8*(SHARES-1) must not exceed 64");
    end
    if (SHARES < 2 || SHARES > 4) begin : g_bad_shares
        $error("sbox_selftest: SHARES must be 2..4");
    end
    if (LAT < 1 || LAT > 16) begin : g_bad_lat
        $error("sbox_selftest: LAT must be 1..16");
    end
    if (NUM_VEC < 1 || NUM_VEC > 256) begin : g_bad_num_vec
        $error("sbox_selftest: NUM_VEC must be 1..256");
    end

    localparam logic [7:0] LAST_VEC = 8'(NUM_VEC - 1);
    localparam logic [7:0] LAST_DRN = 8'(LAT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [63:0]       lfsr_q, lfsr_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [7:0]        ffx_q, ffx_d;
    logic              pass_q, pass_d;

    logic [LAT-1:0]        dl_vld_q;
    logic [LAT-1:0][7:0]   dl_x_q;

    logic [7:0]        mask_xor;
    logic [7:0]        out_xor;
    logic [7:0]        ref_y;
    logic              chk_fail;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN and DRAIN length are set by the shared counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (cnt_q == LAST_VEC) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == LAST_DRN) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; stimulus is forced to zero whenever not in RUN.
    always_comb begin
        busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done         = (state_q == ST_DONE);
        pass         = pass_q;
        err_cnt      = err_q;
        first_fail_x = ffx_q;
        dbg_state_o  = state_q;
        sbox_in      = '0;
        sbox_rand    = '0;
        if (state_q == ST_RUN) begin
            sbox_in[8*SHARES-1:8] = lfsr_q[MASK_W-1:0];
            sbox_in[7:0]          = cnt_q ^ mask_xor;
            sbox_rand             = lfsr_q[MASK_W +: RAND_W];
        end
    end

    // XOR of the mask bytes, folded into share 0 so all shares recombine to x.
    always_comb begin
        mask_xor = '0;
        for (int i = 0; i < SHARES - 1; i++) begin
            mask_xor = mask_xor ^ lfsr_q[8*i +: 8];
        end
    end

    // Recombine the DUT output shares.
    always_comb begin
        out_xor = '0;
        for (int i = 0; i < SHARES; i++) begin
            out_xor = out_xor ^ sbox_out[8*i +: 8];
        end
    end

    aes_sbox_ref u_ref (
        .x_i (dl_x_q[LAT-1]),
        .y_o (ref_y)
    );

    assign chk_fail = dl_vld_q[LAT-1] && (out_xor != ref_y);

    // Datapath next values: counter, LFSR, error bookkeeping and verdict.
    always_comb begin
        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        err_d  = err_q;
        ffx_d  = ffx_q;
        pass_d = pass_q;
        if (chk_fail) begin
            if (err_q != ERR_MAX) err_d = err_q + 9'd1;
            if (err_q == '0)      ffx_d = dl_x_q[LAT-1];
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lfsr_d = {~seed, seed};
                    cnt_d  = '0;
                    err_d  = '0;
                    ffx_d  = '0;
                    pass_d = 1'b0;
                end
            end
            ST_RUN: begin
                lfsr_d = lfsr_step(lfsr_q);
                cnt_d  = (cnt_q == LAST_VEC) ? 8'd0 : cnt_q + 8'd1;
            end
            ST_DRAIN: begin
                cnt_d = (cnt_q == LAST_DRN) ? 8'd0 : cnt_q + 8'd1;
                // The last vector is checked in the final DRAIN cycle, so
                // the verdict includes that check's outcome.
                if (cnt_q == LAST_DRN) pass_d = (err_d == '0);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lfsr_q <= '0;
            err_q  <= '0;
            ffx_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            err_q  <= err_d;
            ffx_q  <= ffx_d;
            pass_q <= pass_d;
        end
    end

    // {valid, x} delay line matching the S-box latency; empty slots flush it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld_q <= '0;
            dl_x_q   <= '0;
        end else begin
            dl_vld_q[0] <= (state_q == ST_RUN);
            dl_x_q[0]   <= cnt_q;
            for (int i = 1; i < LAT; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_x_q[i]   <= dl_x_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sbox_selftest.sv
// Bench for sbox_selftest with a 3-share, 4-cycle masked S-box model.
module tb_sbox_selftest;
    import sbox_selftest_pkg::*;

    localparam int SHARES  = 3;
    localparam int RAND_W  = 19;
    localparam int LAT     = 4;
    localparam int NUM_VEC = 256;
    localparam int SW      = 8 * SHARES;
    localparam int MW      = 8 * (SHARES - 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     seed = '0;
    logic [SW-1:0]   sbox_in;
    logic [SW-1:0]   sbox_out = '0;
    logic [RAND_W-1:0] sbox_rand;
    logic            busy, done, pass;
    logic [8:0]      err_cnt;
    logic [7:0]      first_fail_x;
    state_e          dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sbox_selftest #(
        .SHARES(SHARES), .RAND_W(RAND_W), .LAT(LAT), .NUM_VEC(NUM_VEC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .sbox_in(sbox_in), .sbox_rand(sbox_rand), .sbox_out(sbox_out),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_fail_x(first_fail_x), .dbg_state_o(dbg_state)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    logic [7:0] ref_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sub_bytes(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] b;
        for (int c = 1; c < 256; c++) begin
            if (a != 8'h00 && gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [63:0] poly_step(input logic [63:0] s);
        logic fb = s[63] ^ s[62] ^ s[60] ^ s[59];
        return {s[62:0], fb};
    endfunction

    // ---------------- masked S-box model with fault modes ----------------
    typedef struct packed {
        logic [SW-1:0]     sh;
        logic [RAND_W-1:0] rnd;
    } vec_t;

    vec_t pipe_q[$];
    int   fault_mode = 0;         // 0 correct, 1 flip bit0 of share 1 on listed x, 2 all-zero output
    bit   fault_set [256];

    function automatic logic [7:0] xor_shares(input logic [SW-1:0] v);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < SHARES; i++) r = r ^ v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [SW-1:0] model_out(input vec_t v);
        logic [7:0]    x = xor_shares(v.sh);
        logic [SW-1:0] o;
        logic [7:0]    acc = ref_sbox[x];
        for (int i = 1; i < SHARES; i++) begin
            o[8*i +: 8] = 8'($urandom) ^ v.rnd[7:0];
            acc = acc ^ o[8*i +: 8];
        end
        o[7:0] = acc;
        if (fault_mode == 1 && fault_set[x]) o[8] = ~o[8];
        if (fault_mode == 2) o = '0;
        return o;
    endfunction

    always @(negedge clk) begin : model_pipe
        vec_t cur;
        vec_t old;
        cur.sh  = sbox_in;
        cur.rnd = sbox_rand;
        pipe_q.push_back(cur);
        old = pipe_q.pop_front();
        sbox_out = model_out(old);
    end

    // Expected run verdict from the fault description alone.
    task automatic predict(output int e, output int f);
        e = 0;
        f = 0;
        for (int x = 0; x < NUM_VEC; x++) begin
            logic [7:0] y;
            y = ref_sbox[x];
            if (fault_mode == 1 && fault_set[x]) y = y ^ 8'h01;
            if (fault_mode == 2) y = 8'h00;
            if (y != ref_sbox[x]) begin
                if (e == 0) f = x;
                e++;
            end
        end
        if (e > 511) e = 511;
    endtask

    // ---------------- one full run ----------------
    task automatic do_run(input logic [31:0] sd, input bit poke_start, output logic [31:0] hash);
        logic [63:0] lf;
        int bad_x = 0, bad_mask = 0, bad_rand = 0, bad_busy = 0, bad_quiet = 0, dones = 0;
        int exp_e, exp_f;
        predict(exp_e, exp_f);
        lf   = {~sd, sd};
        hash = 32'h0;
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= NUM_VEC + LAT + 1; j++) begin
            if (j > 1) @(negedge clk);
            if (poke_start) begin
                start = 1'($urandom_range(0, 1));
                seed  = $urandom;
            end
            if (j == NUM_VEC + LAT + 1) start = 1'b0;
            if (done) dones++;
            if (j <= NUM_VEC) begin
                if (xor_shares(sbox_in) != 8'(j - 1)) bad_x++;
                if (sbox_in[SW-1:8] != lf[MW-1:0]) bad_mask++;
                if (sbox_rand != lf[MW +: RAND_W]) bad_rand++;
                if (!busy) bad_busy++;
                hash = {hash[30:0], hash[31]} ^ 32'(sbox_in[SW-1:8]);
                lf = poly_step(lf);
            end else if (j <= NUM_VEC + LAT) begin
                if (!busy) bad_busy++;
                if (sbox_in != '0 || sbox_rand != '0) bad_quiet++;
            end else begin
                check("done_at_260", done, 1);
                check("busy_in_done", busy, 0);
            end
        end
        check("share_xor_is_x", bad_x, 0);
        check("mask_from_lfsr", bad_mask, 0);
        check("rand_from_lfsr", bad_rand, 0);
        check("busy_run_drain", bad_busy, 0);
        check("drain_inputs_zero", bad_quiet, 0);
        check("one_done_pulse", dones, 1);
        check("err_cnt", err_cnt, exp_e);
        check("first_fail_x", first_fail_x, exp_f);
        check("pass", pass, (exp_e == 0) ? 1 : 0);
        @(negedge clk);
        check("idle_state", dbg_state, ST_IDLE);
        check("idle_done_low", done, 0);
        check("hold_err_cnt", err_cnt, exp_e);
        check("hold_ffx", first_fail_x, exp_f);
        check("hold_pass", pass, (exp_e == 0) ? 1 : 0);
        check("idle_inputs_zero", {sbox_in, sbox_rand}, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [31:0] h_a, h_b, h_tmp;
        int dones;
        for (int x = 0; x < 256; x++) begin
            ref_sbox[x] = sub_bytes(8'(x));
            fault_set[x] = 1'b0;
        end
        for (int i = 0; i < LAT; i++) pipe_q.push_back('0);

        // Reset values.
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ffx", first_fail_x, 0);
        check("rst_inputs", {sbox_in, sbox_rand}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Clean runs with the reference seed and a random seed.
        fault_mode = 0;
        do_run(32'h1234_5678, 1'b0, h_a);
        do_run($urandom | 32'h1, 1'b0, h_b);
        check("seed_changes_masks", (h_a != h_b) ? 1 : 0, 1);

        // Single corrupted output at x=0x53.
        fault_mode = 1;
        fault_set[8'h53] = 1'b1;
        do_run(32'h1234_5678, 1'b0, h_tmp);
        fault_set[8'h53] = 1'b0;

        // Output stuck at zero.
        fault_mode = 2;
        do_run(32'h1234_5678, 1'b0, h_tmp);

        // Random fault set, start/seed jiggled throughout RUN and DRAIN.
        fault_mode = 1;
        for (int r = 0; r < 3; r++) fault_set[$urandom_range(0, NUM_VEC - 1)] = 1'b1;
        do_run($urandom, 1'b1, h_tmp);
        for (int x = 0; x < 256; x++) fault_set[x] = 1'b0;

        // Reset in RUN cycle 100 after an early mismatch.
        fault_set[5] = 1'b1;
        @(negedge clk);
        seed  = 32'hCAFE_F00D;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("pre_abort_err", err_cnt, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_err", err_cnt, 0);
        check("abort_ffx", first_fail_x, 0);
        check("abort_inputs", {sbox_in, sbox_rand}, 0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_idle", dbg_state, ST_IDLE);
        fault_set[5] = 1'b0;
        fault_mode = 0;
        do_run($urandom, 1'b0, h_tmp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
